// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the register file and its scoreboard.
//   CPU_DATA_W : default register width
//   CPU_ADDR_W : default register index width
//   reg_idx_t  : register index type at the default width
//   REG_ZERO   : index of the hardwired-zero register
package cpu_pkg;

    localparam int CPU_DATA_W = 32;
    localparam int CPU_ADDR_W = 5;

    typedef logic [CPU_ADDR_W-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/gpr_scoreboard.sv
// Busy-bit scoreboard for the general-purpose register file.
// One busy bit per register marks an in-flight producer. Decode sets the bit
// on an accepted issue, writeback clears it, and flush clears all bits.
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   i_wen, i_wreg  : writeback write enable / index (clears busy)
//   i_iss_en       : issue request from decode
//   i_iss_reg      : destination register of the issuing instruction
//   i_flush        : clear every busy bit
//   o_iss_stall    : issue refused this cycle (WAW on a busy register)
//   o_busy_vec     : raw busy bits, bit 0 always 0
//
// Issue handshake: i_iss_en is the request and o_iss_stall is the inverse of
// ready. The issue is taken on a rising edge where i_iss_en=1, o_iss_stall=0
// and i_flush=0; while stalled, decode holds i_iss_en and i_iss_reg stable.
module gpr_scoreboard
    import cpu_pkg::*;
#(
    parameter int ADDR_W = CPU_ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_wen,
    input  logic [ADDR_W-1:0]    i_wreg,
    input  logic                 i_iss_en,
    input  logic [ADDR_W-1:0]    i_iss_reg,
    input  logic                 i_flush,
    output logic                 o_iss_stall,
    output logic [2**ADDR_W-1:0] o_busy_vec
);

    localparam int NREG = 2**ADDR_W;

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_nxt;
    logic            w_stall;
    logic            w_iss_acc;

    // A write to the same register in the same cycle retires the old
    // producer, so the new issue does not have to wait for it.
    always_comb begin
        w_stall = i_iss_en & r_busy[i_iss_reg]
                & ~(i_wen & (i_wreg == i_iss_reg)) & ~i_flush;
    end

    assign w_iss_acc = i_iss_en & ~w_stall & ~i_flush
                     & (i_iss_reg != ADDR_W'(REG_ZERO));

    // Order matters: flush first, then writeback clear, then issue set, so
    // a new producer wins over a same-cycle writeback to its register.
    always_comb begin
        w_busy_nxt = i_flush ? '0 : r_busy;
        if (i_wen) begin
            w_busy_nxt[i_wreg] = 1'b0;
        end
        if (w_iss_acc) begin
            w_busy_nxt[i_iss_reg] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign o_iss_stall = w_stall;
    assign o_busy_vec  = r_busy;

endmodule

// File: rtl/sb_gpr.sv
// General-purpose register file with per-register busy scoreboard.
// NREG = 2**ADDR_W registers of DATA_W bits, NRD combinational read ports
// with optional write-to-read bypass, one write port. Register 0 reads 0.
//
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   i_radr / o_rdata        : read indices / data, port k in slice k
//   o_rbusy                 : port k's register has an outstanding producer
//   i_wen, i_wreg, i_wdata  : writeback port
//   i_iss_en, i_iss_reg     : issue request from decode
//   o_iss_stall             : issue refused (WAW on busy register)
//   i_flush                 : clear all busy bits
//   o_busy_vec              : raw busy bits
module sb_gpr
    import cpu_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W,
    parameter int ADDR_W = CPU_ADDR_W,
    parameter int NRD    = 3,
    parameter int BYPASS = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NRD*ADDR_W-1:0] i_radr,
    output logic [NRD*DATA_W-1:0] o_rdata,
    output logic [NRD-1:0]        o_rbusy,
    input  logic                  i_wen,
    input  logic [ADDR_W-1:0]     i_wreg,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic                  i_iss_en,
    input  logic [ADDR_W-1:0]     i_iss_reg,
    output logic                  o_iss_stall,
    input  logic                  i_flush,
    output logic [2**ADDR_W-1:0]  o_busy_vec
);

    localparam int NREG = 2**ADDR_W;

    logic [DATA_W-1:0] r_mem [NREG];
    logic [NREG-1:0]   w_busy_vec;
    logic              w_wr_ok;

    assign w_wr_ok = i_wen && (i_wreg != ADDR_W'(REG_ZERO));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_mem[i_wreg] <= i_wdata;
        end
    end

    gpr_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_sb (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_wen       (w_wr_ok),
        .i_wreg      (i_wreg),
        .i_iss_en    (i_iss_en),
        .i_iss_reg   (i_iss_reg),
        .i_flush     (i_flush),
        .o_iss_stall (o_iss_stall),
        .o_busy_vec  (w_busy_vec)
    );

    assign o_busy_vec = w_busy_vec;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_radr;
        logic              w_hit;
        logic [DATA_W-1:0] w_data;
        logic              w_busy;

        assign w_radr = i_radr[k*ADDR_W +: ADDR_W];
        // Bypass is gated by reset so every port reads 0 while held in reset.
        assign w_hit  = (BYPASS != 0) && rst_n && w_wr_ok && (i_wreg == w_radr);

        always_comb begin
            w_data = '0;
            w_busy = 1'b0;
            if (w_radr == ADDR_W'(REG_ZERO)) begin
                w_data = '0;
                w_busy = 1'b0;
            end else if (w_hit) begin
                w_data = i_wdata;
                w_busy = 1'b0;
            end else begin
                w_data = r_mem[w_radr];
                w_busy = w_busy_vec[w_radr];
            end
        end

        assign o_rdata[k*DATA_W +: DATA_W] = w_data;
        assign o_rbusy[k]                  = w_busy;
    end

endmodule

// File: tb/tb_sb_gpr.sv
module tb_sb_gpr;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NR   = 3;
    localparam int NREG = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NR*AW-1:0] i_radr;
    logic             i_wen;
    logic [AW-1:0]    i_wreg;
    logic [DW-1:0]    i_wdata;
    logic             i_iss_en;
    logic [AW-1:0]    i_iss_reg;
    logic             i_flush;

    logic [NR*DW-1:0] rdata_b, rdata_n;
    logic [NR-1:0]    rbusy_b, rbusy_n;
    logic             stall_b, stall_n;
    logic [NREG-1:0]  bvec_b, bvec_n;

    sb_gpr #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .BYPASS(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .i_radr(i_radr), .o_rdata(rdata_b),
        .o_rbusy(rbusy_b), .i_wen(i_wen), .i_wreg(i_wreg), .i_wdata(i_wdata),
        .i_iss_en(i_iss_en), .i_iss_reg(i_iss_reg), .o_iss_stall(stall_b),
        .i_flush(i_flush), .o_busy_vec(bvec_b)
    );

    sb_gpr #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .BYPASS(0)) dut_n (
        .clk(clk), .rst_n(rst_n), .i_radr(i_radr), .o_rdata(rdata_n),
        .o_rbusy(rbusy_n), .i_wen(i_wen), .i_wreg(i_wreg), .i_wdata(i_wdata),
        .i_iss_en(i_iss_en), .i_iss_reg(i_iss_reg), .o_iss_stall(stall_n),
        .i_flush(i_flush), .o_busy_vec(bvec_n)
    );

    // ---------------- reference model ----------------
    logic [DW-1:0] mem_m  [NREG];
    bit            busy_m [NREG];

    int n_checks = 0;
    int n_err    = 0;

    logic [63:0] exp_q[$];
    int          tag_q[$];
    event        sample_ev;

    string knames [8] = '{"rdata_byp", "rbusy_byp", "stall_byp", "busyvec_byp",
                          "rdata_nobyp", "rbusy_nobyp", "stall_nobyp", "busyvec_nobyp"};

    function automatic logic [63:0] m_data(int a, bit byp);
        if (!rst_n || a == 0) return 64'd0;
        if (byp && i_wen && int'(i_wreg) == a) return 64'(i_wdata);
        return 64'(mem_m[a]);
    endfunction

    function automatic logic [63:0] m_busy(int a, bit byp);
        if (!rst_n || a == 0) return 64'd0;
        if (byp && i_wen && int'(i_wreg) == a) return 64'd0;
        return busy_m[a] ? 64'd1 : 64'd0;
    endfunction

    function automatic bit m_stall();
        if (!rst_n) return 1'b0;
        return i_iss_en && busy_m[int'(i_iss_reg)]
            && !(i_wen && i_wreg == i_iss_reg) && !i_flush;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input bit wen, input int wreg, input logic [31:0] wdata,
                         input bit iss, input int ireg, input bit fl,
                         input int r0, input int r1, input int r2);
        i_wen     = wen;
        i_wreg    = wreg[AW-1:0];
        i_wdata   = wdata;
        i_iss_en  = iss;
        i_iss_reg = ireg[AW-1:0];
        i_flush   = fl;
        i_radr    = {r2[AW-1:0], r1[AW-1:0], r0[AW-1:0]};
    endtask

    task automatic push_checks();
        logic [63:0] v;
        int a;
        for (int p = 0; p < NR; p++) begin
            a = int'(i_radr[p*AW +: AW]);
            exp_q.push_back(m_data(a, 1'b1)); tag_q.push_back(0*8 + p);
            exp_q.push_back(m_busy(a, 1'b1)); tag_q.push_back(1*8 + p);
            exp_q.push_back(m_data(a, 1'b0)); tag_q.push_back(4*8 + p);
            exp_q.push_back(m_busy(a, 1'b0)); tag_q.push_back(5*8 + p);
        end
        exp_q.push_back(64'(m_stall())); tag_q.push_back(2*8);
        exp_q.push_back(64'(m_stall())); tag_q.push_back(6*8);
        v = '0;
        for (int i = 0; i < NREG; i++) v[i] = busy_m[i];
        exp_q.push_back(v); tag_q.push_back(3*8);
        exp_q.push_back(v); tag_q.push_back(7*8);
        #2;
        -> sample_ev;
    endtask

    task automatic tick();
        bit st;
        st = m_stall();
        @(posedge clk);
        if (rst_n) begin
            if (i_flush) for (int i = 0; i < NREG; i++) busy_m[i] = 1'b0;
            if (i_wen && i_wreg != '0) begin
                mem_m[int'(i_wreg)]  = i_wdata;
                busy_m[int'(i_wreg)] = 1'b0;
            end
            if (i_iss_en && !st && !i_flush && i_iss_reg != '0)
                busy_m[int'(i_iss_reg)] = 1'b1;
        end
        #1;
    endtask

    task automatic cyc(input bit wen, input int wreg, input logic [31:0] wdata,
                       input bit iss, input int ireg, input bit fl,
                       input int r0, input int r1, input int r2);
        drive(wen, wreg, wdata, iss, ireg, fl, r0, r1, r2);
        push_checks();
        tick();
    endtask

    task automatic model_clear();
        for (int i = 0; i < NREG; i++) begin
            mem_m[i]  = '0;
            busy_m[i] = 1'b0;
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    function automatic logic [63:0] act_of(int tag);
        int k;
        int p;
        k = tag / 8;
        p = tag % 8;
        case (k)
            0: return 64'(rdata_b[p*DW +: DW]);
            1: return 64'(rbusy_b[p]);
            2: return 64'(stall_b);
            3: return 64'(bvec_b);
            4: return 64'(rdata_n[p*DW +: DW]);
            5: return 64'(rbusy_n[p]);
            6: return 64'(stall_n);
            default: return 64'(bvec_n);
        endcase
    endfunction

    initial begin
        logic [63:0] e;
        logic [63:0] act;
        int t;
        forever begin
            @(sample_ev);
            while (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                t   = tag_q.pop_front();
                act = act_of(t);
                n_checks++;
                if (act !== e) begin
                    n_err++;
                    $display("FAIL %s[%0d] @%0t: got %h expected %h",
                             knames[t / 8], t % 8, $time, act, e);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        model_clear();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        push_checks();                       // reset state
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset mid-operation
        cyc(1, 7, 32'hDEADBEEF, 1, 8, 0, 7, 7, 7);
        drive(1, 7, 32'h11111111, 1, 10, 0, 7, 8, 0);
        push_checks();
        #1;
        rst_n = 1'b0;
        model_clear();
        #1;
        push_checks();
        tick();
        push_checks();
        drive(0, 0, 0, 0, 0, 0, 7, 8, 10);
        rst_n = 1'b1;
        cyc(0, 0, 0, 0, 0, 0, 7, 8, 10);

        // Register 0 protection
        cyc(1, 0, 32'h12345678, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Bypass on r5 (port 2)
        cyc(1, 5, 32'h0BADF00D, 0, 0, 0, 1, 3, 5);
        cyc(1, 5, 32'hA5A5A5A5, 0, 0, 0, 1, 3, 5);
        cyc(0, 0, 0, 0, 0, 0, 5, 5, 5);

        // Scoreboard lifecycle on r9
        cyc(0, 0, 0, 1, 9, 0, 9, 0, 0);
        cyc(0, 0, 0, 1, 9, 0, 9, 0, 0);
        cyc(1, 9, 32'h00000055, 0, 0, 0, 9, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 9, 9, 0);

        // Same-cycle write + issue on busy r3
        cyc(0, 0, 0, 1, 3, 0, 3, 0, 0);
        cyc(1, 3, 32'hCAFE0003, 1, 3, 0, 3, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 3, 3, 3);

        // Flush with a simultaneous issue
        cyc(0, 0, 0, 1, 1, 0, 1, 2, 4);
        cyc(0, 0, 0, 1, 2, 0, 1, 2, 4);
        cyc(0, 0, 0, 1, 4, 0, 1, 2, 4);
        cyc(0, 0, 0, 1, 6, 1, 1, 2, 6);
        cyc(0, 0, 0, 1, 1, 0, 6, 1, 4);

        // Flush + write on busy r11
        cyc(0, 0, 0, 1, 11, 0, 11, 0, 0);
        cyc(1, 11, 32'h0000BEEF, 1, 11, 1, 11, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 11, 11, 11);

        // Randomised traffic, indices biased to a small set for collisions
        for (int n = 0; n < 400; n++) begin
            int wr, ir, r0, r1, r2;
            wr = int'($urandom_range(0, 7));
            ir = ($urandom_range(0, 3) == 0) ? wr : int'($urandom_range(0, 7));
            r0 = int'($urandom_range(0, 7));
            r1 = ($urandom_range(0, 1) == 1) ? wr : int'($urandom_range(0, 31));
            r2 = ($urandom_range(0, 1) == 1) ? ir : int'($urandom_range(0, 7));
            cyc(1'($urandom_range(0, 1)), wr, $urandom,
                1'($urandom_range(0, 1)), ir, ($urandom_range(0, 19) == 0),
                r0, r1, r2);
        end

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/sb_gpr.md
# sb_gpr

Parametrised general-purpose register file with scoreboard for the pipelined CPU. It holds NREG registers of DATA_W bits and provides NRD combinational read ports with write-to-read bypass and one write port. A per-register busy bit tracks in-flight producers: decode sets it at issue and writeback clears it. Register 0 is hardwired to zero. The block sits between decode (reads, issue) and writeback (write).

## Interface
- DATA_W, 32, register width
- ADDR_W, 5, register index width; NREG = 2**ADDR_W
- NRD, 3, number of read ports
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see stored value only
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- i_radr  in  NRD*ADDR_W  read indices, port k at bits [k*ADDR_W +: ADDR_W]
- o_rdata  out  NRD*DATA_W  read data, port k at bits [k*DATA_W +: DATA_W]
- o_rbusy  out  NRD  port k's register has an outstanding producer
- i_wen  in  1  write enable
- i_wreg  in  ADDR_W  write index
- i_wdata  in  DATA_W  write data
- i_iss_en  in  1  issue request: mark i_iss_reg busy
- i_iss_reg  in  ADDR_W  destination of issuing instruction
- o_iss_stall  out  1  issue refused this cycle (WAW on busy register)
- i_flush  in  1  clear all busy bits (pipeline flush)
- o_busy_vec  out  NREG  raw busy bits, for debug/hazard unit

## Operation
- Reset (rst_n=0, asynchronous): all NREG registers cleared to 0, all busy bits cleared. Outputs during reset: o_rdata = 0 on every port, o_rbusy = 0, o_iss_stall = 0, o_busy_vec = 0.
- Write: if i_wen and i_wreg≠0, mem[i_wreg] ← i_wdata at the edge, and busy[i_wreg] ← 0. Writes to register 0 are discarded. Writes to non-busy registers are legal.
- Read port k (combinational):
  - i_radr=0 → data 0, busy 0.
  - BYPASS=1 and i_wen and i_wreg=i_radr≠0 → data = i_wdata, busy 0.
  - Otherwise data = mem[i_radr], busy = busy[i_radr].
- Issue:
  - o_iss_stall = i_iss_en & busy[i_iss_reg] & ~(i_wen & i_wreg==i_iss_reg) & ~i_flush.
  - Accepted issue (i_iss_en & ~o_iss_stall & ~i_flush & i_iss_reg≠0) sets busy[i_iss_reg] at the edge.
  - Issue to register 0 is accepted and has no effect.
- Simultaneous events, same register, same cycle:
  - Write + accepted issue → mem updated, busy ends 1 (new producer wins).
  - Flush + issue → flush wins: all busy bits 0, issue ignored, no stall.
  - Flush + write → write performed, busy 0.
- Busy bit of register 0 is constant 0.

## Timing
- Read latency 0 (combinational from i_radr, i_wreg, i_wdata, i_wen).
- Write visible through stored path the cycle after the edge. With BYPASS=1 it is also visible in the same cycle.
- Busy set/clear takes effect at the edge and is visible on o_rbusy/o_busy_vec the next cycle.
- o_iss_stall is combinational in the issue cycle. Decode holds the request while stalled.
- Reset asserted mid-operation clears state immediately, regardless of clk. Deassertion is synchronised externally.

## Structure
- Shared package `cpu_pkg`: DATA_W/ADDR_W defaults, `reg_idx_t` typedef, `REG_ZERO` constant.
- Sub-module `gpr_scoreboard`: busy vector, issue/clear/flush logic, and o_iss_stall. The top module holds the storage array and read/bypass muxes.

## Test plan
- Reset: write 0xDEADBEEF to r7, then pull rst_n low between edges → o_rdata for r7 reads 0 immediately, o_busy_vec = 0.
- r0 protection: i_wen, i_wreg=0, i_wdata=0x12345678; read r0 on all ports → 0 same cycle and after the edge; issue r0 → no stall, busy_vec = 0.
- Bypass: i_wen to r5 with 0xA5A5A5A5 while port 2 reads r5 → data 0xA5A5A5A5 same cycle with BYPASS=1. With BYPASS=0 it reads the old value, and the new value the next cycle.
- Scoreboard lifecycle: issue r9 → o_rbusy for r9 = 1 next cycle; second issue r9 → o_iss_stall=1; write r9 = 0x55 → busy 0 next cycle and read 0x55.
- Same-cycle write + issue on r3 (r3 busy): no stall, busy_vec[3]=1 after the edge, mem r3 = written data.
- Flush: issue r1, r2, r4 over 3 cycles, then i_flush together with issue r6 → busy_vec = 0 after the edge, r6 not busy, o_iss_stall = 0.
